// File: rtl/ysyx_24090003_pkg.sv
// Shared constants for the instruction-fetch unit: FSM state encoding,
// default boot address and instruction width.
package ysyx_24090003_pkg;

  localparam int INST_W = 32;

  localparam logic [31:0] RESET_PC_DFLT = 32'h8000_0000;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

endpackage

// File: rtl/ysyx_24090003_sync_fifo.sv
// Synchronous FIFO with a zero-latency head and a single-cycle flush.
// Flush wins over push/pop; storage itself is not reset, only pointers/count.
module ysyx_24090003_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  // Entry storage, written only by a surviving push.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/ysyx_24090003_ifu_fq.sv
// Instruction-fetch unit with a credit-based instruction queue.
// Requests are only issued when a queue slot is guaranteed for the response,
// redirects flush the queue and mark in-flight responses for discard.
module ysyx_24090003_ifu_fq
  import ysyx_24090003_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DFLT,
  parameter int              DEPTH    = 4
) (
  input  logic              cpu_clk,
  input  logic              cpu_rs,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [XLEN-1:0]   req_addr,
  input  logic              rsp_valid,
  input  logic [INST_W-1:0] rsp_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  input  logic              halt,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   npc
);

  localparam int CW = $clog2(DEPTH) + 1;
  // Killed requests can still be in flight after a redirect, so the
  // outstanding counter is sized well beyond the queue depth.
  localparam int OW = $clog2(DEPTH) + 4;
  localparam int EW = XLEN + INST_W;

  logic [1:0]      r_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [OW-1:0]   r_out;
  logic [OW-1:0]   r_kill;

  logic [CW-1:0]   w_count;
  logic [EW-1:0]   w_head;
  logic [OW-1:0]   w_live;
  logic [OW-1:0]   w_used;
  logic            w_req_valid;
  logic            w_req_fire;
  logic            w_push;
  logic            w_pop;
  logic            w_inst_valid;
  logic [XLEN-1:0] w_pc;

  // Credit check uses registered occupancy only, keeping inst_ready off the req_valid path.
  assign w_live       = r_out - r_kill;
  assign w_used       = {{(OW-CW){1'b0}}, w_count} + w_live;
  assign w_req_valid  = (r_state == ST_FETCH) && !redirect_valid && !halt &&
                        (w_used < OW'(DEPTH));
  assign w_req_fire   = w_req_valid && req_ready;
  assign w_push       = rsp_valid && !redirect_valid && (r_kill == '0);
  assign w_inst_valid = (w_count != '0);
  assign w_pop        = w_inst_valid && inst_ready && !redirect_valid;

  // Control FSM: BOOT lasts one cycle, HALT is sticky until reset.
  always_ff @(posedge cpu_clk or negedge cpu_rs) begin
    if (!cpu_rs) begin
      r_state <= ST_BOOT;
    end else begin
      case (r_state)
        ST_BOOT:  r_state <= ST_FETCH;
        ST_FETCH: if (halt) r_state <= ST_HALT;
        default:  r_state <= ST_HALT;
      endcase
    end
  end

  // Fetch/response PCs and in-flight accounting; redirect overrides everything else.
  always_ff @(posedge cpu_clk or negedge cpu_rs) begin
    if (!cpu_rs) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_out      <= '0;
      r_kill     <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
      r_resp_pc  <= redirect_pc;
      r_out      <= r_out - OW'(rsp_valid);
      r_kill     <= r_out - OW'(rsp_valid);
    end else begin
      if (w_req_fire) r_fetch_pc <= r_fetch_pc + XLEN'(4);
      if (w_push)     r_resp_pc  <= r_resp_pc + XLEN'(4);
      r_out <= r_out + OW'(w_req_fire) - OW'(rsp_valid);
      if (rsp_valid && (r_kill != '0)) r_kill <= r_kill - OW'(1);
    end
  end

  ysyx_24090003_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (cpu_clk),
    .i_rst_n (cpu_rs),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_data  ({r_resp_pc, rsp_data}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count)
  );

  // With an empty queue the outputs show the PC the next instruction will carry.
  assign w_pc       = w_inst_valid ? w_head[EW-1:INST_W] : r_resp_pc;
  assign req_valid  = w_req_valid;
  assign req_addr   = r_fetch_pc;
  assign inst_valid = w_inst_valid;
  assign inst       = w_inst_valid ? w_head[INST_W-1:0] : '0;
  assign pc         = w_pc;
  assign npc        = w_pc + XLEN'(4);

endmodule

// File: tb/tb_ysyx_24090003_ifu_fq.sv
// Scoreboard bench for the fetch unit: a latency-configurable memory model
// answers requests, expected {pc,inst} entries are queued at request time
// and compared when decode accepts an instruction.
module tb_ysyx_24090003_ifu_fq;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        cpu_clk = 1'b0;
  logic        cpu_rs;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] npc;

  ysyx_24090003_ifu_fq dut (
    .cpu_clk        (cpu_clk),
    .cpu_rs         (cpu_rs),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .pc             (pc),
    .npc            (npc)
  );

  always #5 cpu_clk = ~cpu_clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  int          n_req  = 0;
  int          mem_lat = 1;
  logic        mem_en  = 1'b1;
  logic [31:0] mem_q[$];
  int          mem_t[$];
  logic [31:0] exp_q[$];
  logic [31:0] pop_pcs[$];
  logic [31:0] exp_addr = RPC;
  logic        hold_v = 1'b0;
  logic [31:0] hold_a = '0;
  logic        s_req_valid, s_inst_valid, s_rsp_valid;
  logic [31:0] s_req_addr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // One clock cycle: drive memory response, observe handshakes, advance.
  task automatic step();
    logic [31:0] e;
    @(negedge cpu_clk);
    rsp_valid = 1'b0;
    rsp_data  = '0;
    if (mem_en && mem_q.size() > 0 && (mem_t[0] + mem_lat <= cyc)) begin
      rsp_valid = 1'b1;
      rsp_data  = memf(mem_q[0]);
      void'(mem_q.pop_front());
      void'(mem_t.pop_front());
    end
    #1;
    s_req_valid  = req_valid;
    s_req_addr   = req_addr;
    s_inst_valid = inst_valid;
    s_rsp_valid  = rsp_valid;
    if (hold_v && req_valid) check("req_hold", req_addr, hold_a);
    hold_v = req_valid && !req_ready;
    hold_a = req_addr;
    if (redirect_valid) check("redir_noreq", req_valid, 1'b0);
    if (req_valid && req_ready) begin
      check("req_addr", req_addr, exp_addr);
      mem_q.push_back(req_addr);
      mem_t.push_back(cyc);
      exp_q.push_back(exp_addr);
      exp_addr = exp_addr + 32'd4;
      n_req++;
    end
    if (inst_valid && inst_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        check("pop_unexp", inst_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("pop_pc", pc, e);
        check("pop_inst", inst, memf(e));
        check("pop_npc", npc, e + 32'd4);
        pop_pcs.push_back(pc);
      end
    end
    if (redirect_valid) begin
      exp_q.delete();
      exp_addr = redirect_pc;
    end
    cyc++;
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic do_reset(input logic chk);
    @(negedge cpu_clk);
    cpu_rs = 1'b0;
    redirect_valid = 1'b0;
    halt = 1'b0;
    rsp_valid = 1'b0;
    rsp_data = '0;
    #1;
    if (chk) begin
      check("rst_req_valid", req_valid, 1'b0);
      check("rst_inst_valid", inst_valid, 1'b0);
      check("rst_inst", inst, 32'h0);
      check("rst_pc", pc, RPC);
      check("rst_npc", npc, RPC + 32'd4);
    end
    mem_q.delete();
    mem_t.delete();
    exp_q.delete();
    exp_addr = RPC;
    hold_v = 1'b0;
    @(posedge cpu_clk);
    @(posedge cpu_clk);
    #1;
    cpu_rs = 1'b1;
    n_req = 0;
    pop_pcs.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cpu_rs = 1'b0;
    req_ready = 1'b1;
    inst_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    halt = 1'b0;
    rsp_valid = 1'b0;
    rsp_data = '0;

    // Streaming after reset, one request per cycle.
    do_reset(1'b1);
    mem_lat = 1; mem_en = 1'b1;
    step();
    check("boot_noreq", s_req_valid, 1'b0);
    repeat (10) step();
    check("t1_reqs", n_req, 10);
    check("t1_pops", pop_pcs.size(), 8);
    if (pop_pcs.size() > 0) check("t1_first_pc", pop_pcs[0], RPC);

    // Decode stalled: credit limit of 4, then resume.
    do_reset(1'b0);
    inst_ready = 1'b0;
    step();
    repeat (12) step();
    check("t2_reqs", n_req, 4);
    check("t2_req_low", s_req_valid, 1'b0);
    check("t2_inst_valid", s_inst_valid, 1'b1);
    inst_ready = 1'b1;
    repeat (20) step();
    check("t2_resumed", n_req > 4, 1'b1);

    // Redirect with two outstanding requests and a non-empty queue.
    do_reset(1'b0);
    inst_ready = 1'b0;
    repeat (4) step();
    mem_en = 1'b0;
    repeat (2) step();
    check("t3_outst", mem_q.size(), 2);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100; inst_ready = 1'b1;
    step();
    check("t3_pre_valid", s_inst_valid, 1'b1);
    redirect_valid = 1'b0; mem_en = 1'b1;
    pop_pcs.delete();
    step();
    check("t3_flushed", s_inst_valid, 1'b0);
    repeat (10) step();
    check("t3_popped", pop_pcs.size() > 0, 1'b1);
    if (pop_pcs.size() > 0) check("t3_first_pc", pop_pcs[0], 32'h8000_0100);

    // Redirect coinciding with a response and a pop.
    do_reset(1'b0);
    mem_lat = 2;
    step();
    repeat (8) step();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    step();
    check("t4_setup", {s_rsp_valid, s_inst_valid}, 2'b11);
    redirect_valid = 1'b0;
    pop_pcs.delete();
    repeat (12) step();
    check("t4_popped", pop_pcs.size() > 0, 1'b1);
    if (pop_pcs.size() > 0) check("t4_first_pc", pop_pcs[0], 32'h8000_0200);

    // Halt with three requests in flight.
    do_reset(1'b0);
    mem_lat = 1; mem_en = 1'b0;
    repeat (4) step();
    halt = 1'b1;
    step();
    check("t5_halt_noreq", s_req_valid, 1'b0);
    check("t5_outst", mem_q.size(), 3);
    halt = 1'b0; mem_en = 1'b1;
    n_req = 0;
    pop_pcs.delete();
    repeat (10) step();
    check("t5_no_new_req", n_req, 0);
    check("t5_drained", pop_pcs.size(), 3);

    // Reset in the middle of a burst.
    do_reset(1'b0);
    repeat (6) step();
    do_reset(1'b1);
    step();
    step();
    check("t6_req_valid", s_req_valid, 1'b1);
    check("t6_first_addr", s_req_addr, RPC);

    // Random backpressure, memory stalls and redirects.
    do_reset(1'b0);
    mem_lat = 2;
    for (int i = 0; i < 300; i++) begin
      req_ready  = ($urandom % 4) != 0;
      inst_ready = ($urandom % 3) != 0;
      mem_en     = ($urandom % 4) != 0;
      redirect_valid = ($urandom % 25) == 0;
      redirect_pc = 32'h8000_1000 + (i << 4);
      step();
    end
    redirect_valid = 1'b0; req_ready = 1'b0; inst_ready = 1'b1; mem_en = 1'b1;
    repeat (20) step();
    check("rand_exp_empty", exp_q.size(), 0);
    check("rand_mem_empty", mem_q.size(), 0);
    check("rand_inst_idle", s_inst_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_24090003_ifu_fq.md
YSYX_24090003_IFU_FQ -- requirements
Module: ysyx_24090003_ifu_fq

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC/address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h8000_0000: first fetch address after reset.
REQ-003 SHALL have parameter DEPTH, default 4: instruction-queue entries; power of two, 2..16.
REQ-004 SHALL have port cpu_clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port cpu_rs  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have ports req_valid out 1, req_ready in 1, req_addr out XLEN: instruction-memory request; transfer when both valid and ready.
REQ-007 SHALL have ports rsp_valid in 1, rsp_data in 32: in-order response, always accepted, at least 1 cycle after its request transfer.
REQ-008 SHALL have ports redirect_valid in 1, redirect_pc in XLEN: single-cycle control-flow change from EX.
REQ-009 SHALL have port halt in 1: stop issuing new fetches (ebreak/trap).
REQ-010 SHALL have ports inst_valid out 1, inst_ready in 1, inst out 32, pc out XLEN, npc out XLEN: decode-side output; transfer when both high.

Function
REQ-011 SHALL implement FSM states BOOT, FETCH, HALT; reset enters BOOT; BOOT->FETCH on the next edge; FETCH->HALT when halt=1; HALT exits only via reset.
REQ-012 SHALL track fetch_pc (next request address), resp_pc (PC of next accepted response), outstanding (in-flight requests, killed included), kill_cnt (in-flight responses to discard), count (queue occupancy).
REQ-013 SHALL drive req_valid=1 only in FETCH, redirect_valid=0, halt=0, and (count + outstanding - kill_cnt) < DEPTH; req_addr=fetch_pc.
REQ-014 SHALL, on request transfer, set fetch_pc <= fetch_pc+4 (modulo 2^XLEN) and increment outstanding.
REQ-015 SHALL, on rsp_valid, decrement outstanding; if kill_cnt>0, discard the data and decrement kill_cnt; else push {resp_pc, rsp_data} and set resp_pc <= resp_pc+4.
REQ-016 SHALL never overflow the queue; credit rule REQ-013 reserves a slot for every live request.
REQ-017 SHALL drive inst_valid=(count!=0), inst/pc from the queue head, npc=pc+4; pop on inst_valid&inst_ready; zero-latency head, no combinational path from inst_ready to req_valid.
REQ-018 SHALL support push and pop in the same cycle, count unchanged.
REQ-019 SHALL, on redirect_valid, take priority over push/pop: empty the queue, set fetch_pc <= redirect_pc and resp_pc <= redirect_pc, kill_cnt <= outstanding - rsp_valid (any response in that cycle is discarded), issue no request that cycle.
REQ-020 SHALL accept back-to-back redirects; the last one wins.
REQ-021 SHALL, in HALT, still drain outstanding responses into the queue and present them to decode.
REQ-022 SHALL hold req_addr stable while req_valid=1 and req_ready=0, unless redirect_valid deasserts req_valid.

Reset
REQ-023 SHALL, while cpu_rs=0, force: state=BOOT, fetch_pc=resp_pc=RESET_PC, outstanding=kill_cnt=count=0, queue pointers 0, req_valid=0, inst_valid=0, inst=0, pc=RESET_PC, npc=RESET_PC+4.
REQ-024 SHALL discard all in-flight transactions on reset; memory side is reset together.

Structure
REQ-025 SHALL place state encoding (BOOT/FETCH/HALT), RESET_PC default, and the instruction width 32 in shared package ysyx_24090003_pkg.
REQ-026 SHALL instantiate one sub-module ysyx_24090003_sync_fifo (width XLEN+32, depth DEPTH, with flush) for the queue.

Verification
REQ-027 Reset release, req_ready=1, 1-cycle memory, inst_ready=1 -> req_addr 0x80000000, 0x80000004, ... one per cycle; inst_valid/pc follow in order with npc=pc+4.
REQ-028 inst_ready=0, DEPTH=4 -> exactly 4 requests issued, req_valid low thereafter, count=4; inst_ready=1 resumes fetch with no lost or duplicated pc.
REQ-029 Redirect to 0x80000100 with 2 outstanding -> queue empties, next 2 responses dropped, next inst pc=0x80000100.
REQ-030 Redirect in the same cycle as a response and a pop -> response dropped, no pop effect, kill_cnt=outstanding-1.
REQ-031 halt=1 with 3 outstanding -> no new requests, 3 instructions still delivered, state stays HALT.
REQ-032 cpu_rs low mid-burst, then high -> all outputs at REQ-023 values, fetch restarts at 0x80000000.
